// File: rtl/sgpr_pkg.sv
// rtl/sgpr_pkg.sv - shared widths and default sizing for the scalar register file
//
// Purpose: common constants and word types for sgpr_multiport and sgpr_rd_port.
// Ports: none (package).
package sgpr_pkg;

  localparam int DWORD_W        = 32;
  localparam int QWORD_W        = 64;

  localparam int DEFAULT_DEPTH  = 512;
  localparam int DEFAULT_ADDR_W = 9;
  localparam int DEFAULT_NUM_RD = 4;
  localparam int DEFAULT_NUM_WR = 2;
  localparam int DEFAULT_WFID_W = 6;

  typedef logic [DWORD_W-1:0] dword_t;
  typedef logic [QWORD_W-1:0] qword_t;

endpackage

// File: rtl/sgpr_rd_port.sv
// rtl/sgpr_rd_port.sv - one 64-bit read port: address wrap, write-first bypass, output register
//
// Purpose: presents the two dword addresses of a qword read to the array, merges
// same-cycle write data over the array words (highest write port wins), and
// registers the result with a one-cycle latency.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_en, rd_addr      read request and base dword address
//   wr_en/addr/data     all write ports, used only for the bypass
//   lo_addr, hi_addr    dword addresses looked up in the array by the parent
//   lo_word, hi_word    array contents at lo_addr / hi_addr
//   rd_data, rd_valid   registered {dword[addr+1], dword[addr]} and valid
module sgpr_rd_port
  import sgpr_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_WR = DEFAULT_NUM_WR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [NUM_WR*2-1:0]       wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR*QWORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0]         lo_addr,
  output logic [ADDR_W-1:0]         hi_addr,
  input  dword_t                    lo_word,
  input  dword_t                    hi_word,
  output qword_t                    rd_data,
  output logic                      rd_valid
);

  dword_t lo_next;
  dword_t hi_next;

  // DEPTH is a power of two, so the natural ADDR_W-bit overflow is the wrap.
  assign lo_addr = rd_addr;
  assign hi_addr = rd_addr + ADDR_W'(1);

  // Walk write ports in ascending order so a later (higher) port overrides an
  // earlier one, matching the priority used when the array is committed.
  always_comb begin
    lo_next = lo_word;
    hi_next = hi_word;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[2*p] && (wr_addr[p*ADDR_W +: ADDR_W] == lo_addr))
        lo_next = wr_data[p*QWORD_W +: DWORD_W];
      if (wr_en[2*p+1] && ((wr_addr[p*ADDR_W +: ADDR_W] + ADDR_W'(1)) == lo_addr))
        lo_next = wr_data[p*QWORD_W+DWORD_W +: DWORD_W];
      if (wr_en[2*p] && (wr_addr[p*ADDR_W +: ADDR_W] == hi_addr))
        hi_next = wr_data[p*QWORD_W +: DWORD_W];
      if (wr_en[2*p+1] && ((wr_addr[p*ADDR_W +: ADDR_W] + ADDR_W'(1)) == hi_addr))
        hi_next = wr_data[p*QWORD_W+DWORD_W +: DWORD_W];
    end
  end

  // rd_data holds its last value when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= {hi_next, lo_next};
    end
  end

endmodule

// File: rtl/sgpr_multiport.sv
// rtl/sgpr_multiport.sv - multi-ported scalar register file with done/dest notifications
//
// Purpose: DEPTH x 32-bit register array with NUM_RD 64-bit read ports and
// NUM_WR 64-bit write ports (per-dword enables), all completing every cycle.
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   rd_en, rd_addr, rd_data, rd_valid     per-port reads, 1-cycle latency
//   wr_en, wr_addr, wr_data               per-port writes, bit0 low / bit1 high dword
//   wr_done, wr_done_wfid                 per-port instruction-done strobe and wfid
//   issue_wr_done, issue_wr_done_wfid     done strobe/wfid delayed one cycle
//   issue_dest_addr, issue_dest_valid     write address/enables delayed one cycle
module sgpr_multiport
  import sgpr_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = DEFAULT_NUM_RD,
  parameter int NUM_WR = DEFAULT_NUM_WR,
  parameter int WFID_W = DEFAULT_WFID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*QWORD_W-1:0] rd_data,
  output logic [NUM_RD-1:0]         rd_valid,
  input  logic [NUM_WR*2-1:0]       wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR*QWORD_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]         wr_done,
  input  logic [NUM_WR*WFID_W-1:0]  wr_done_wfid,
  output logic [NUM_WR-1:0]         issue_wr_done,
  output logic [NUM_WR*WFID_W-1:0]  issue_wr_done_wfid,
  output logic [NUM_WR*ADDR_W-1:0]  issue_dest_addr,
  output logic [NUM_WR*2-1:0]       issue_dest_valid
);

  dword_t            mem [DEPTH];
  logic [ADDR_W-1:0] wr_hi_addr [NUM_WR];

  always_comb begin
    for (int p = 0; p < NUM_WR; p++)
      wr_hi_addr[p] = wr_addr[p*ADDR_W +: ADDR_W] + ADDR_W'(1);
  end

  // Array contents are deliberately not reset; writes are simply ignored while
  // rst is high. Ascending port order makes the highest-numbered port the last
  // assignment, so it wins a same-dword conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[2*p])
          mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*QWORD_W +: DWORD_W];
        if (wr_en[2*p+1])
          mem[wr_hi_addr[p]] <= wr_data[p*QWORD_W+DWORD_W +: DWORD_W];
      end
    end
  end

  // Notifications are registered on the same edge that commits the write, so
  // issue sees done exactly when the data becomes readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_wr_done      <= '0;
      issue_wr_done_wfid <= '0;
      issue_dest_addr    <= '0;
      issue_dest_valid   <= '0;
    end else begin
      issue_wr_done      <= wr_done;
      issue_wr_done_wfid <= wr_done_wfid;
      issue_dest_addr    <= wr_addr;
      issue_dest_valid   <= wr_en;
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;
    dword_t            lo_word;
    dword_t            hi_word;

    assign lo_word = mem[lo_addr];
    assign hi_word = mem[hi_addr];

    sgpr_rd_port #(
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_rd_port (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en[r]),
      .rd_addr  (rd_addr[r*ADDR_W +: ADDR_W]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .lo_addr  (lo_addr),
      .hi_addr  (hi_addr),
      .lo_word  (lo_word),
      .hi_word  (hi_word),
      .rd_data  (rd_data[r*QWORD_W +: QWORD_W]),
      .rd_valid (rd_valid[r])
    );
  end

endmodule

// File: tb/tb_sgpr_multiport.sv
// tb/tb_sgpr_multiport.sv - self-checking bench for sgpr_multiport
module tb_sgpr_multiport;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int NUM_RD = 4;
  localparam int NUM_WR = 2;
  localparam int WFID_W = 6;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_RD-1:0]         rd_en = '0;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr = '0;
  logic [NUM_RD*64-1:0]      rd_data;
  logic [NUM_RD-1:0]         rd_valid;
  logic [NUM_WR*2-1:0]       wr_en = '0;
  logic [NUM_WR*ADDR_W-1:0]  wr_addr = '0;
  logic [NUM_WR*64-1:0]      wr_data = '0;
  logic [NUM_WR-1:0]         wr_done = '0;
  logic [NUM_WR*WFID_W-1:0]  wr_done_wfid = '0;
  logic [NUM_WR-1:0]         issue_wr_done;
  logic [NUM_WR*WFID_W-1:0]  issue_wr_done_wfid;
  logic [NUM_WR*ADDR_W-1:0]  issue_dest_addr;
  logic [NUM_WR*2-1:0]       issue_dest_valid;

  int n_cmp = 0;
  int n_bad = 0;

  sgpr_multiport #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .WFID_W(WFID_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_done            (wr_done),
    .wr_done_wfid       (wr_done_wfid),
    .issue_wr_done      (issue_wr_done),
    .issue_wr_done_wfid (issue_wr_done_wfid),
    .issue_dest_addr    (issue_dest_addr),
    .issue_dest_valid   (issue_dest_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain dword array. Each cycle the writes land in port
  // order (later port overwrites), then every enabled read looks at the updated
  // array, which is exactly write-first with highest-port priority.
  logic [31:0]              mmem [DEPTH];
  logic [63:0]              exp_rd [NUM_RD];
  logic [NUM_RD-1:0]        exp_valid = '0;
  logic [NUM_WR-1:0]        exp_done = '0;
  logic [NUM_WR*WFID_W-1:0] exp_wfid = '0;
  logic [NUM_WR*ADDR_W-1:0] exp_daddr = '0;
  logic [NUM_WR*2-1:0]      exp_dvalid = '0;

  task automatic model_zero();
    for (int r = 0; r < NUM_RD; r++) exp_rd[r] = '0;
    exp_valid = '0; exp_done = '0; exp_wfid = '0; exp_daddr = '0; exp_dvalid = '0;
  endtask

  initial begin
    model_zero();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_zero();
      end else begin
        for (int p = 0; p < NUM_WR; p++) begin
          int a;
          a = int'(wr_addr[p*ADDR_W +: ADDR_W]);
          if (wr_en[2*p])   mmem[a] = wr_data[p*64 +: 32];
          if (wr_en[2*p+1]) mmem[(a + 1) % DEPTH] = wr_data[p*64+32 +: 32];
        end
        for (int r = 0; r < NUM_RD; r++) begin
          int a;
          a = int'(rd_addr[r*ADDR_W +: ADDR_W]);
          exp_valid[r] = rd_en[r];
          if (rd_en[r]) exp_rd[r] = {mmem[(a + 1) % DEPTH], mmem[a]};
        end
        exp_done   = wr_done;
        exp_wfid   = wr_done_wfid;
        exp_daddr  = wr_addr;
        exp_dvalid = wr_en;
      end
      @(negedge clk);
      if (rst) model_zero();
      for (int r = 0; r < NUM_RD; r++)
        chk($sformatf("rd_data%0d", r), 256'(rd_data[r*64 +: 64]), 256'(exp_rd[r]));
      chk("rd_valid", 256'(rd_valid), 256'(exp_valid));
      chk("issue_wr_done", 256'(issue_wr_done), 256'(exp_done));
      chk("issue_wr_done_wfid", 256'(issue_wr_done_wfid), 256'(exp_wfid));
      chk("issue_dest_addr", 256'(issue_dest_addr), 256'(exp_daddr));
      chk("issue_dest_valid", 256'(issue_dest_valid), 256'(exp_dvalid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr_en = '0; wr_done = '0;
  endtask

  task automatic set_rd(input int r, input int a);
    rd_en[r] = 1'b1;
    rd_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic set_wr(input int p, input logic [1:0] en, input int a, input logic [63:0] d);
    wr_en[2*p +: 2] = en;
    wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[p*64 +: 64] = d;
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 7);
      1: return $urandom_range(DEPTH - 4, DEPTH - 1);
      default: return $urandom_range(0, DEPTH - 1);
    endcase
  endfunction

  initial begin
    // Reset values while rst is held
    repeat (3) tick();
    chk("reset_rd_data", 256'(rd_data), 256'(0));
    chk("reset_rd_valid", 256'(rd_valid), 256'(0));
    chk("reset_issue", 256'({issue_wr_done, issue_wr_done_wfid, issue_dest_addr, issue_dest_valid}), 256'(0));
    rst = 1'b0;

    // Fill the whole array so every later read has a known value
    for (int a = 0; a < DEPTH; a += 2) begin
      set_wr(0, 2'b11, a, {$urandom, $urandom});
      tick();
    end
    idle();
    tick();

    // Low-dword write then read on port 3
    set_wr(0, 2'b01, 50, {32'h0BAD0BAD, 32'hF0F0F0F0});
    tick();
    idle();
    set_rd(3, 50);
    tick();
    chk("req033_data", 256'(rd_data[3*64 +: 32]), 256'(32'hF0F0F0F0));
    chk("req033_valid", 256'(rd_valid[3]), 256'(1));
    idle();
    tick();
    chk("req033_valid_drop", 256'(rd_valid[3]), 256'(0));
    chk("req033_hold", 256'(rd_data[3*64 +: 32]), 256'(32'hF0F0F0F0));

    // Full qword write on port 1, then aligned and straddling reads
    set_wr(1, 2'b11, 100, 64'hDEADDEAD_AAAAA0A0);
    tick();
    idle();
    set_rd(1, 100);
    tick();
    chk("req034_addr100", 256'(rd_data[1*64 +: 64]), 256'(64'hDEADDEAD_AAAAA0A0));
    set_rd(1, 99);
    tick();
    chk("req034_addr99_hi", 256'(rd_data[1*64+32 +: 32]), 256'(32'hAAAAA0A0));
    idle();

    // Write at the top address wraps its high dword to dword 0
    set_wr(0, 2'b11, 511, 64'h12344321_DEADBABE);
    tick();
    idle();
    set_rd(0, 511);
    set_rd(2, 0);
    tick();
    chk("req035_addr511", 256'(rd_data[0 +: 64]), 256'(64'h12344321_DEADBABE));
    chk("req035_dword0", 256'(rd_data[2*64 +: 32]), 256'(32'h12344321));
    idle();

    // Same-dword conflict with a same-cycle read: port 1 wins, bypassed
    set_wr(0, 2'b01, 7, {32'h0, 32'h11111111});
    set_wr(1, 2'b01, 7, {32'h0, 32'h22222222});
    set_rd(2, 7);
    tick();
    chk("req036_bypass", 256'(rd_data[2*64 +: 32]), 256'(32'h22222222));
    idle();
    set_rd(2, 7);
    tick();
    chk("req036_stored", 256'(rd_data[2*64 +: 32]), 256'(32'h22222222));
    idle();

    // Done strobe delayed by exactly one cycle, one cycle wide
    wr_done[0] = 1'b1;
    wr_done_wfid[0 +: WFID_W] = 6'd13;
    tick();
    chk("req037_done", 256'(issue_wr_done[0]), 256'(1));
    chk("req037_wfid", 256'(issue_wr_done_wfid[0 +: WFID_W]), 256'(13));
    idle();
    tick();
    chk("req037_pulse", 256'(issue_wr_done[0]), 256'(0));

    // Asynchronous reset during active reads and done; write during reset ignored
    rd_en = '1;
    wr_done = '1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("req038_async_rd", 256'(rd_data), 256'(0));
    chk("req038_async_flags", 256'({rd_valid, issue_wr_done, issue_wr_done_wfid, issue_dest_valid}), 256'(0));
    set_wr(0, 2'b11, 50, 64'h0);
    tick();
    tick();
    chk("req038_held", 256'({rd_valid, issue_wr_done}), 256'(0));
    rst = 1'b0;
    idle();
    tick();
    chk("req038_first_valid", 256'(rd_valid), 256'(0));
    set_rd(0, 50);
    tick();
    chk("req038_reg50", 256'(rd_data[0 +: 32]), 256'(32'hF0F0F0F0));
    idle();

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NUM_RD; r++) begin
        rd_en[r] = 1'($urandom_range(0, 1));
        rd_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(rand_addr());
      end
      for (int p = 0; p < NUM_WR; p++) begin
        wr_en[2*p +: 2] = 2'($urandom_range(0, 3));
        wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(rand_addr());
        wr_data[p*64 +: 64] = {$urandom, $urandom};
        wr_done[p] = 1'($urandom_range(0, 1));
        wr_done_wfid[p*WFID_W +: WFID_W] = WFID_W'($urandom);
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sgpr_multiport.md
SGPR_MULTIPORT -- requirements
Module: sgpr_multiport

Interface
REQ-001 Parameter DEPTH, default 512, number of 32-bit scalar registers; SHALL be a power of two.
REQ-002 Parameter ADDR_W, default 9, register address width; SHALL equal log2(DEPTH).
REQ-003 Parameter NUM_RD, default 4, number of independent 64-bit read ports.
REQ-004 Parameter NUM_WR, default 2, number of independent 64-bit write ports.
REQ-005 Parameter WFID_W, default 6, wavefront id width.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 rd_en  in  NUM_RD  per-port read request.
REQ-009 rd_addr  in  NUM_RD*ADDR_W  per-port base dword address.
REQ-010 rd_data  out  NUM_RD*64  per-port {dword[addr+1], dword[addr]}.
REQ-011 rd_valid  out  NUM_RD  per-port read-data-valid.
REQ-012 wr_en  in  NUM_WR*2  per-port dword enables; bit0 low dword, bit1 high dword.
REQ-013 wr_addr  in  NUM_WR*ADDR_W  per-port base dword address.
REQ-014 wr_data  in  NUM_WR*64  per-port write data, low dword in [31:0].
REQ-015 wr_done, wr_done_wfid  in  NUM_WR, NUM_WR*WFID_W  per-port instruction-done strobe and wfid.
REQ-016 issue_wr_done, issue_wr_done_wfid  out  NUM_WR, NUM_WR*WFID_W  registered done notification to issue.
REQ-017 issue_dest_addr, issue_dest_valid  out  NUM_WR*ADDR_W, NUM_WR*2  registered copy of committed write address and enables.

Function
REQ-018 Write commit: at rising edge, each enabled dword SHALL be stored; low dword at addr, high dword at (addr+1) mod DEPTH (wrap DEPTH-1 -> 0).
REQ-019 Same-dword write conflict in one cycle: highest-numbered write port SHALL win; losing dword discarded, no error flag.
REQ-020 Read latency SHALL be exactly 1 cycle: rd_en sampled at edge N; rd_data and rd_valid updated at edge N; rd_valid = registered rd_en.
REQ-021 Read-during-write, same dword, same cycle: rd_data SHALL return the newly written value (write-first bypass), applying REQ-019 priority.
REQ-022 Read high dword SHALL use (addr+1) mod DEPTH.
REQ-023 rd_en low: rd_data SHALL hold its previous value; rd_valid SHALL be 0.
REQ-024 issue_dest_addr/issue_dest_valid SHALL equal wr_addr/wr_en of the same port delayed one cycle; valid bits 0 in idle cycles.
REQ-025 issue_wr_done SHALL equal wr_done delayed one cycle, issue_wr_done_wfid the matching wfid; asserted in the same cycle as the corresponding write's data becoming readable.
REQ-026 Ports SHALL be fully independent; all NUM_RD reads and NUM_WR writes complete every cycle, no stalls, no backpressure.

Reset
REQ-027 While rst high: rd_data, rd_valid, issue_wr_done, issue_wr_done_wfid, issue_dest_addr, issue_dest_valid SHALL be 0.
REQ-028 Register array contents SHALL NOT be reset; writes with rst high SHALL be ignored.
REQ-029 Reset asserted mid-operation SHALL drop in-flight reads and done notifications; first cycle after deassertion produces no rd_valid.

Structure
REQ-030 Shared package sgpr_pkg SHALL hold DWORD_W=32, QWORD_W=64, and the default DEPTH/NUM_RD/NUM_WR/WFID_W constants.
REQ-031 Read path SHALL be one sub-module sgpr_rd_port (address decode, wrap, bypass mux, output register), instanced NUM_RD times.
REQ-032 Write priority and done/notification registers SHALL reside in the top module.

Verification
REQ-033 Port0 wr_en=01, addr=50, data low F0F0F0F0; next cycle read port3 addr 50 -> rd_data[31:0]=F0F0F0F0, rd_valid3=1 one cycle later.
REQ-034 Port1 wr_en=11, addr=100, data DEADDEAD_AAAAA0A0; read port1 addr 100 and 99 -> 100: DEADDEAD_AAAAA0A0; 99: high dword AAAAA0A0.
REQ-035 Write addr=511, wr_en=11, data 12344321_DEADBABE; read addr 511 -> 12344321_DEADBABE, dword 0 = 12344321.
REQ-036 Ports 0 and 1 both write addr 7 low dword (11111111 vs 22222222) same cycle while port2 reads 7 -> port2 returns 22222222, later reads 22222222.
REQ-037 wr_done=1, wfid=6'd13 on port0 -> issue_wr_done0=1, wfid 13 exactly one cycle later, one-cycle pulse.
REQ-038 Assert rst during active read and done -> all outputs 0 asynchronously; previously written register 50 still reads F0F0F0F0 after release.
